// File: rtl/fetch_prefetch_queue.sv
// Fetch stage with PC ownership, single-outstanding memory handshake and a
// DEPTH-entry prefetch FIFO whose head is the IF/ID register.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal fetch: request pc while the queue has room
// DRAIN | waiting out a request abandoned by a redirect; data discarded
module fetch_prefetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    memReq,
  output logic [ADDR_W-1:0]       memAddr,
  input  logic                    memAck,
  input  logic [INST_W-1:0]       memData,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirectPc,
  input  logic                    decodeReady,
  output logic                    instValid,
  output logic [INST_W-1:0]       instOut,
  output logic [ADDR_W-1:0]       instPc,
  output logic [ADDR_W-1:0]       pcPlus4,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] drain_addr;
  logic              pending;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic              fifo_valid;
  logic              pop;
  logic              push;
  logic              space;
  logic              req_int;
  logic [CW-1:0]     count_after_pop;
  logic [ADDR_W-1:0] head_pc;
  logic              enter_drain;

  assign fifo_valid      = (count != '0);
  assign pop             = fifo_valid && decodeReady && !redirect;
  assign count_after_pop = count - CW'(pop);
  assign space           = (count_after_pop < CW'(DEPTH));
  assign push            = (state == RUN) && req_int && memAck;
  // A request issued in an earlier cycle and still unanswered must be drained.
  assign enter_drain     = (state == RUN) && redirect && pending && !memAck;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (enter_drain) state_next = DRAIN;
      DRAIN:   if (memAck)      state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Request outputs per state.
  always_comb begin
    req_int = 1'b0;
    memAddr = pc;
    case (state)
      RUN: begin
        req_int = space && !redirect;
        memAddr = pc;
      end
      DRAIN: begin
        req_int = 1'b1;
        memAddr = drain_addr;
      end
      default: begin
        req_int = 1'b0;
        memAddr = pc;
      end
    endcase
  end

  // Reset must silence the request line immediately, even mid-transaction.
  assign memReq = req_int && !reset;

  // PC, outstanding-request tracking and drain address capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      pending    <= 1'b0;
      drain_addr <= '0;
    end else begin
      if (redirect)  pc <= redirectPc & ~ADDR_W'(3);
      else if (push) pc <= pc + ADDR_W'(4);
      pending <= (state == RUN) && req_int && !memAck;
      if (enter_drain) drain_addr <= pc;
    end
  end

  // FIFO pointers and occupancy; redirect clears everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[wr_ptr] <= memData;
      pc_mem[wr_ptr]   <= pc;
    end
  end

  assign head_pc   = pc_mem[rd_ptr];
  assign instValid = fifo_valid;
  assign instOut   = fifo_valid ? inst_mem[rd_ptr] : '0;
  assign instPc    = fifo_valid ? head_pc : '0;
  assign pcPlus4   = fifo_valid ? head_pc + ADDR_W'(4) : '0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: streaming, full queue, latency,
// redirect with drain, redirect with coincident ack, pc wrap, reset in DRAIN.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] DMASK = 32'h1234_5678;

  logic        clock = 1'b0;
  logic        reset;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        decodeReady;
  logic        instValid;
  logic [31:0] instOut;
  logic [31:0] instPc;
  logic [31:0] pcPlus4;
  logic [2:0]  count;

  logic        reset2;
  logic        memReq2;
  logic [31:0] memAddr2;
  logic        memAck2;
  logic [31:0] memData2;
  logic        redirect2;
  logic [31:0] redirectPc2;
  logic        decodeReady2;
  logic        instValid2;
  logic [31:0] instOut2;
  logic [31:0] instPc2;
  logic [31:0] pcPlus4_2;
  logic [2:0]  count2;

  logic        zero_wait;
  logic        ack_manual;
  logic        data_ovr_en;
  logic [31:0] data_ovr;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  // Memory model: zero-wait acks follow memReq, otherwise ack is driven by hand.
  assign memAck  = zero_wait ? memReq : ack_manual;
  assign memData = data_ovr_en ? data_ovr : (memAddr ^ DMASK);

  assign memAck2     = memReq2;
  assign memData2    = ~memAddr2;
  assign redirect2   = 1'b0;
  assign redirectPc2 = 32'h0;

  fetch_prefetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clock(clock), .reset(reset), .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memData(memData), .redirect(redirect), .redirectPc(redirectPc),
    .decodeReady(decodeReady), .instValid(instValid), .instOut(instOut),
    .instPc(instPc), .pcPlus4(pcPlus4), .count(count)
  );

  fetch_prefetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clock(clock), .reset(reset2), .memReq(memReq2), .memAddr(memAddr2),
    .memAck(memAck2), .memData(memData2), .redirect(redirect2), .redirectPc(redirectPc2),
    .decodeReady(decodeReady2), .instValid(instValid2), .instOut(instOut2),
    .instPc(instPc2), .pcPlus4(pcPlus4_2), .count(count2)
  );

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Holds reset for two edges, releases it 1 time unit after an edge (cycle 0).
  task automatic apply_reset(input logic zw, input logic dr);
    reset       = 1'b1;
    redirect    = 1'b0;
    redirectPc  = 32'h0;
    ack_manual  = 1'b0;
    data_ovr_en = 1'b0;
    data_ovr    = 32'h0;
    zero_wait   = zw;
    decodeReady = dr;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; zero_wait = 1'b1; decodeReady = 1'b1; redirect = 1'b0;
    redirectPc = 32'h0; ack_manual = 1'b0; data_ovr_en = 1'b0; data_ovr = 32'h0;
    next_cycle();
    tests_run++; if (memReq !== 1'b0) begin tests_failed++; $display("FAIL reset_memReq: got %b expected 0", memReq); end
    tests_run++; if (instValid !== 1'b0) begin tests_failed++; $display("FAIL reset_instValid: got %b expected 0", instValid); end
    tests_run++; if (instOut !== 32'h0) begin tests_failed++; $display("FAIL reset_instOut: got %h expected 0", instOut); end
    tests_run++; if (instPc !== 32'h0 || pcPlus4 !== 32'h0) begin tests_failed++; $display("FAIL reset_pcs: got %h/%h expected 0/0", instPc, pcPlus4); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
  endtask

  task automatic test_stream();
    apply_reset(1'b1, 1'b1);
    #1;
    tests_run++; if (memReq !== 1'b1 || memAddr !== 32'h0) begin tests_failed++; $display("FAIL stream_first_req: got %b/%h expected 1/00000000", memReq, memAddr); end
    tests_run++; if (instValid !== 1'b0) begin tests_failed++; $display("FAIL stream_fill_latency: got %b expected 0", instValid); end
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      #1;
      tests_run++; if (memAddr !== 32'(4*k)) begin tests_failed++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, memAddr, 32'(4*k)); end
      tests_run++; if (instValid !== 1'b1 || instPc !== 32'(4*(k-1)) || pcPlus4 !== 32'(4*k)) begin
        tests_failed++; $display("FAIL stream_head[%0d]: got v=%b pc=%h p4=%h expected v=1 pc=%h p4=%h", k, instValid, instPc, pcPlus4, 32'(4*(k-1)), 32'(4*k)); end
      tests_run++; if (instOut !== (32'(4*(k-1)) ^ DMASK) || count !== 3'd1) begin
        tests_failed++; $display("FAIL stream_data[%0d]: got inst=%h count=%0d expected inst=%h count=1", k, instOut, count, 32'(4*(k-1)) ^ DMASK); end
    end
  endtask

  task automatic test_full();
    apply_reset(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) next_cycle();
    #1;
    tests_run++; if (count !== 3'd4 || memReq !== 1'b0) begin tests_failed++; $display("FAIL full_stop: got count=%0d req=%b expected count=4 req=0", count, memReq); end
    next_cycle();
    tests_run++; if (memReq !== 1'b0 || instPc !== 32'h0) begin tests_failed++; $display("FAIL full_hold: got req=%b pc=%h expected req=0 pc=0", memReq, instPc); end
    decodeReady = 1'b1;
    #1;
    tests_run++; if (memReq !== 1'b1 || memAddr !== 32'h10) begin tests_failed++; $display("FAIL full_pop_req: got req=%b addr=%h expected req=1 addr=00000010", memReq, memAddr); end
    next_cycle();
    decodeReady = 1'b0;
    #1;
    tests_run++; if (count !== 3'd4 || instPc !== 32'h4 || memReq !== 1'b0) begin
      tests_failed++; $display("FAIL full_after_pop: got count=%0d pc=%h req=%b expected count=4 pc=4 req=0", count, instPc, memReq); end
  endtask

  task automatic test_latency();
    apply_reset(1'b0, 1'b0);
    #1;
    for (int k = 0; k < 3; k++) begin
      tests_run++; if (memReq !== 1'b1 || memAddr !== 32'h0 || instValid !== 1'b0) begin
        tests_failed++; $display("FAIL lat_wait[%0d]: got req=%b addr=%h v=%b expected req=1 addr=0 v=0", k, memReq, memAddr, instValid); end
      next_cycle();
      #1;
    end
    ack_manual = 1'b1;
    #1;
    tests_run++; if (memAddr !== 32'h0 || instValid !== 1'b0) begin tests_failed++; $display("FAIL lat_ack_cycle: got addr=%h v=%b expected addr=0 v=0", memAddr, instValid); end
    next_cycle();
    ack_manual = 1'b0;
    #1;
    tests_run++; if (instValid !== 1'b1 || instPc !== 32'h0 || memAddr !== 32'h4) begin
      tests_failed++; $display("FAIL lat_fill: got v=%b pc=%h addr=%h expected v=1 pc=0 addr=4", instValid, instPc, memAddr); end
  endtask

  // Leaves the DUT in DRAIN with the 0x8 request outstanding, redirected to 0x103.
  task automatic enter_drain();
    apply_reset(1'b1, 1'b0);
    next_cycle();
    next_cycle();
    zero_wait = 1'b0; ack_manual = 1'b0;
    #1;
    tests_run++; if (memAddr !== 32'h8 || memReq !== 1'b1) begin tests_failed++; $display("FAIL drain_pending: got req=%b addr=%h expected req=1 addr=8", memReq, memAddr); end
    next_cycle();
    redirect = 1'b1; redirectPc = 32'h103;
    #1;
    tests_run++; if (memReq !== 1'b0) begin tests_failed++; $display("FAIL drain_redirect_req: got %b expected 0", memReq); end
    next_cycle();
    redirect = 1'b0;
  endtask

  task automatic test_redirect_drain();
    enter_drain();
    #1;
    tests_run++; if (memReq !== 1'b1 || memAddr !== 32'h8) begin tests_failed++; $display("FAIL drain_hold0: got req=%b addr=%h expected req=1 addr=8", memReq, memAddr); end
    tests_run++; if (instValid !== 1'b0 || count !== 3'd0) begin tests_failed++; $display("FAIL drain_empty: got v=%b count=%0d expected v=0 count=0", instValid, count); end
    next_cycle();
    tests_run++; if (memAddr !== 32'h8) begin tests_failed++; $display("FAIL drain_hold1: got %h expected 8", memAddr); end
    next_cycle();
    ack_manual = 1'b1; data_ovr_en = 1'b1; data_ovr = 32'hDEAD;
    #1;
    tests_run++; if (memAddr !== 32'h8) begin tests_failed++; $display("FAIL drain_ack_addr: got %h expected 8", memAddr); end
    next_cycle();
    ack_manual = 1'b0; data_ovr_en = 1'b0; zero_wait = 1'b1;
    #1;
    tests_run++; if (memReq !== 1'b1 || memAddr !== 32'h100 || instValid !== 1'b0) begin
      tests_failed++; $display("FAIL drain_new_req: got req=%b addr=%h v=%b expected req=1 addr=100 v=0", memReq, memAddr, instValid); end
    next_cycle();
    tests_run++; if (instValid !== 1'b1 || instPc !== 32'h100 || instOut !== (32'h100 ^ DMASK)) begin
      tests_failed++; $display("FAIL drain_new_data: got v=%b pc=%h inst=%h expected v=1 pc=100 inst=%h", instValid, instPc, instOut, 32'h100 ^ DMASK); end
  endtask

  task automatic test_redirect_ack();
    apply_reset(1'b1, 1'b0);
    next_cycle();
    next_cycle();
    zero_wait = 1'b0; ack_manual = 1'b0;
    #1;
    tests_run++; if (count !== 3'd2 || memAddr !== 32'h8) begin tests_failed++; $display("FAIL rack_setup: got count=%0d addr=%h expected count=2 addr=8", count, memAddr); end
    next_cycle();
    redirect = 1'b1; redirectPc = 32'h40; decodeReady = 1'b1; ack_manual = 1'b1;
    next_cycle();
    redirect = 1'b0; decodeReady = 1'b0; ack_manual = 1'b0;
    #1;
    tests_run++; if (count !== 3'd0 || instValid !== 1'b0) begin tests_failed++; $display("FAIL rack_flush: got count=%0d v=%b expected count=0 v=0", count, instValid); end
    tests_run++; if (memReq !== 1'b1 || memAddr !== 32'h40) begin tests_failed++; $display("FAIL rack_next_req: got req=%b addr=%h expected req=1 addr=40", memReq, memAddr); end
    next_cycle();
    zero_wait = 1'b1;
    next_cycle();
    tests_run++; if (instValid !== 1'b1 || instPc !== 32'h40 || pcPlus4 !== 32'h44) begin
      tests_failed++; $display("FAIL rack_fill: got v=%b pc=%h p4=%h expected v=1 pc=40 p4=44", instValid, instPc, pcPlus4); end
  endtask

  task automatic test_wrap();
    decodeReady2 = 1'b0;
    next_cycle();
    reset2 = 1'b0;
    #1;
    tests_run++; if (memReq2 !== 1'b1 || memAddr2 !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_first_req: got req=%b addr=%h expected req=1 addr=fffffffc", memReq2, memAddr2); end
    next_cycle();
    tests_run++; if (instValid2 !== 1'b1 || instPc2 !== 32'hFFFF_FFFC || pcPlus4_2 !== 32'h0) begin
      tests_failed++; $display("FAIL wrap_head: got v=%b pc=%h p4=%h expected v=1 pc=fffffffc p4=0", instValid2, instPc2, pcPlus4_2); end
    tests_run++; if (memAddr2 !== 32'h0 || instOut2 !== 32'h3) begin tests_failed++; $display("FAIL wrap_next: got addr=%h inst=%h expected addr=0 inst=3", memAddr2, instOut2); end
    next_cycle();
    tests_run++; if (count2 !== 3'd2 || memAddr2 !== 32'h4) begin tests_failed++; $display("FAIL wrap_count: got count=%0d addr=%h expected count=2 addr=4", count2, memAddr2); end
    reset2 = 1'b1;
  endtask

  task automatic test_reset_in_drain();
    enter_drain();
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if (memReq !== 1'b0 || instValid !== 1'b0 || count !== 3'd0) begin
      tests_failed++; $display("FAIL rst_drain: got req=%b v=%b count=%0d expected 0/0/0", memReq, instValid, count); end
    tests_run++; if (instOut !== 32'h0 || instPc !== 32'h0 || pcPlus4 !== 32'h0) begin
      tests_failed++; $display("FAIL rst_drain_out: got %h/%h/%h expected 0/0/0", instOut, instPc, pcPlus4); end
    zero_wait = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    tests_run++; if (memReq !== 1'b1 || memAddr !== 32'h0) begin tests_failed++; $display("FAIL rst_drain_restart: got req=%b addr=%h expected req=1 addr=0", memReq, memAddr); end
  endtask

  initial begin
    reset2 = 1'b1;
    decodeReady2 = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_latency();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap();
    test_reset_in_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
